rs_gf_mult: RTL and testbench

// - Registered GF(2^m) multiplier: y = a * b mod P(x), where P(x) = x^m + pp.
// - Field arithmetic primitive for the RS encoder/decoder datapaths, such as the encoder's

---
 rtl/rs_gf_mult_pkg.sv | 28 ++
 rtl/rs_gf_mult_if.sv | 33 +++
 rtl/rs_gf_mult_comb.sv | 37 +++
 rtl/rs_gf_mult.sv | 50 +++++
 tb/tb_rs_gf_mult.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/rs_gf_mult_pkg.sv
// Shared GF(2^m) constants and the xtime helper for the RS arithmetic blocks.
package rs_gf_mult_pkg;

  // Default symbol width; widths up to MaxWidth are supported by gf_xtime.
  localparam int unsigned GfWidthDefault = 4;
  localparam int unsigned MaxWidth       = 16;

  // Field polynomials without the implicit x^m term.
  localparam logic [3:0] Gf16Poly     = 4'b0011;  // x^4 + x + 1
  localparam logic [7:0] Gf256Poly1D  = 8'h1D;    // x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [7:0] Gf256Poly1B  = 8'h1B;    // x^8 + x^4 + x^3 + x + 1

  // Multiply v by x modulo x^w + p. Operands live in the low w bits of a 16-bit word,
  // so a single function covers every legal width.
  function automatic logic [MaxWidth-1:0] gf_xtime(input logic [MaxWidth-1:0] v,
                                                   input logic [MaxWidth-1:0] p,
                                                   input int unsigned         w);
    logic [MaxWidth-1:0] mask;
    logic [MaxWidth-1:0] r;
    logic [3:0]          msb_idx;
    // For w == 16 the shift wraps to zero and the subtraction yields all ones.
    mask    = (16'h1 << w) - 16'h1;
    msb_idx = 4'(w - 1);
    r       = {v[MaxWidth-2:0], 1'b0} ^ (v[msb_idx] ? p : '0);
    return r & mask;
  endfunction

endpackage

// File: rtl/rs_gf_mult_if.sv
// Operand/result bundle for the registered GF(2^m) multiplier.
// All buses are [0:m-1]: index 0 is the x^(m-1) coefficient.
interface rs_gf_mult_if #(
  parameter int unsigned m = 4
) ();

  logic         en;
  logic [0:m-1] a;
  logic [0:m-1] b;
  logic [0:m-1] p;
  logic [0:m-1] y;
  logic         vld;

  // Master supplies operands and the field polynomial; slave returns the product.
  modport master (
    output en,
    output a,
    output b,
    output p,
    input  y,
    input  vld
  );

  modport slave (
    input  en,
    input  a,
    input  b,
    input  p,
    output y,
    output vld
  );

endinterface

// File: rtl/rs_gf_mult_comb.sv
// Combinational GF(2^m) multiplier: Horner evaluation over b, MSB first,
// one xtime-and-add stage per multiplier bit.
module rs_gf_mult_comb
  import rs_gf_mult_pkg::*;
#(
  parameter int unsigned m = GfWidthDefault
) (
  input  logic [0:m-1] a_i,
  input  logic [0:m-1] b_i,
  input  logic [0:m-1] p_i,
  output logic [0:m-1] y_o
);

  logic [m-1:0] a_val;
  logic [m-1:0] p_val;

  // Re-express the [0:m-1] buses as plain numeric vectors; value order is unchanged.
  assign a_val = a_i;
  assign p_val = p_i;

  for (genvar i = 0; i < m; i++) begin : g_stage
    logic [m-1:0] acc_in;
    logic [m-1:0] acc_out;

    if (i == 0) begin : g_first
      assign acc_in = '0;
    end else begin : g_next
      assign acc_in = g_stage[i-1].acc_out;
    end

    // acc = xtime(acc) ^ (b_i ? a : 0); b_i[0] is the x^(m-1) coefficient, consumed first.
    assign acc_out = m'(gf_xtime(16'(acc_in), 16'(p_val), m)) ^ (b_i[i] ? a_val : '0);
  end

  assign y_o = g_stage[m-1].acc_out;

endmodule

// File: rtl/rs_gf_mult.sv
// Registered GF(2^m) multiplier: y <= a * b mod (x^m + p) on each enabled clock.
// The field polynomial is a run-time input so one netlist serves any field of width m.
module rs_gf_mult
  import rs_gf_mult_pkg::*;
#(
  parameter int unsigned m = GfWidthDefault
) (
  input  logic          clk,
  input  logic          syn_rst_n,
  rs_gf_mult_if.slave   bus
);

  logic [0:m-1] prod;
  logic [0:m-1] y_d, y_q;
  logic         vld_d, vld_q;

  rs_gf_mult_comb #(
    .m (m)
  ) u_comb (
    .a_i (bus.a),
    .b_i (bus.b),
    .p_i (bus.p),
    .y_o (prod)
  );

  // Capture the product when enabled; otherwise hold y and drop vld.
  always_comb begin
    y_d   = y_q;
    vld_d = 1'b0;
    if (bus.en) begin
      y_d   = prod;
      vld_d = 1'b1;
    end
  end

  // Result registers; synchronous reset wins over en.
  always_ff @(posedge clk) begin
    if (!syn_rst_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign bus.y   = y_q;
  assign bus.vld = vld_q;

endmodule

// File: tb/tb_rs_gf_mult.sv
// Directed checks of rs_gf_mult at m=4 and m=8 against hand values and a
// carry-less-multiply-then-reduce reference.
module tb_rs_gf_mult;
  import rs_gf_mult_pkg::*;

  logic clk;
  logic syn_rst_n;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned res [16][16];

  rs_gf_mult_if #(.m(4)) if4 ();
  rs_gf_mult_if #(.m(8)) if8 ();

  rs_gf_mult #(.m(4)) u_dut4 (
    .clk       (clk),
    .syn_rst_n (syn_rst_n),
    .bus       (if4)
  );

  rs_gf_mult #(.m(8)) u_dut8 (
    .clk       (clk),
    .syn_rst_n (syn_rst_n),
    .bus       (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Schoolbook carry-less product followed by long division by x^w + p.
  function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b,
                                          input int unsigned p, input int w);
    int unsigned prod;
    prod = 0;
    for (int i = 0; i < w; i++) begin
      if (((b >> i) & 1) != 0) prod ^= a << i;
    end
    for (int i = 2 * w - 2; i >= w; i--) begin
      if (((prod >> i) & 1) != 0) prod ^= ((32'h1 << w) | p) << (i - w);
    end
    return prod;
  endfunction

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap4(input int unsigned a, input int unsigned b);
    if4.en = 1'b1;
    if4.a  = 4'(a);
    if4.b  = 4'(b);
    tick();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    syn_rst_n = 1'b0;
    if4.en = 1'b0; if4.a = '0; if4.b = '0; if4.p = Gf16Poly;
    if8.en = 1'b0; if8.a = '0; if8.b = '0; if8.p = Gf256Poly1D;

    // Reset for two clocks, then release with en low.
    tick();
    tick();
    check_val("rst_y4",   32'(if4.y),   0);
    check_val("rst_vld4", 32'(if4.vld), 0);
    check_val("rst_y8",   32'(if8.y),   0);
    check_val("rst_vld8", 32'(if8.vld), 0);
    syn_rst_n = 1'b1;
    tick();
    tick();
    check_val("idle_y4",   32'(if4.y),   0);
    check_val("idle_vld4", 32'(if4.vld), 0);

    // Hand-computed GF(16) products.
    cap4(4'h2, 4'h8);
    check_val("2x8",     32'(if4.y),   32'h3);
    check_val("2x8_vld", 32'(if4.vld), 1);
    cap4(4'h9, 4'h2);
    check_val("9x2", 32'(if4.y), 32'h1);
    cap4(4'hF, 4'hF);
    check_val("FxF", 32'(if4.y), 32'hA);

    // Identity and zero operands.
    for (int i = 0; i < 16; i++) begin
      cap4(i, 1);
      check_val($sformatf("%0hx1", i), 32'(if4.y), i);
      cap4(i, 0);
      check_val($sformatf("%0hx0", i), 32'(if4.y), 0);
      cap4(0, i);
      check_val($sformatf("0x%0h", i), 32'(if4.y), 0);
    end

    // All pairs back to back, en held high every cycle.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        cap4(i, j);
        res[i][j] = 32'(if4.y);
        check_val($sformatf("ex_%0hx%0h", i, j), res[i][j],
                  ref_mul(i, j, 32'(Gf16Poly), 4));
      end
    end
    check_val("ex_vld", 32'(if4.vld), 1);
    for (int i = 0; i < 16; i++) begin
      for (int j = i + 1; j < 16; j++) begin
        check_val($sformatf("comm_%0h_%0h", i, j), res[i][j], res[j][i]);
      end
    end

    // Enable/reset interplay.
    cap4(4'h3, 4'h7);
    check_val("3x7",     32'(if4.y),   32'h9);
    check_val("3x7_vld", 32'(if4.vld), 1);
    if4.en = 1'b0;
    if4.a  = 4'hF;
    if4.b  = 4'hF;
    tick();
    check_val("hold_y",   32'(if4.y),   32'h9);
    check_val("hold_vld", 32'(if4.vld), 0);
    tick();
    check_val("hold_y2", 32'(if4.y), 32'h9);
    if4.en    = 1'b1;
    if4.a     = 4'h5;
    if4.b     = 4'h5;
    syn_rst_n = 1'b0;
    tick();
    check_val("rst_en_y",   32'(if4.y),   0);
    check_val("rst_en_vld", 32'(if4.vld), 0);
    syn_rst_n = 1'b1;
    cap4(4'h2, 4'h8);
    check_val("post_rst_y",   32'(if4.y),   32'h3);
    check_val("post_rst_vld", 32'(if4.vld), 1);
    if4.en = 1'b0;

    // GF(256) with two different polynomials.
    if8.en = 1'b1;
    if8.p  = Gf256Poly1D;
    if8.a  = 8'h80;
    if8.b  = 8'h02;
    tick();
    check_val("g8_80x02",     32'(if8.y),   32'h1D);
    check_val("g8_80x02_vld", 32'(if8.vld), 1);
    if8.p = Gf256Poly1B;
    if8.a = 8'h53;
    if8.b = 8'hCA;
    tick();
    check_val("g8_53xCA", 32'(if8.y), 32'h01);
    if8.a = 8'hCA;
    if8.b = 8'h53;
    tick();
    check_val("g8_CAx53", 32'(if8.y), 32'h01);
    if8.p = Gf256Poly1D;
    if8.a = 8'h57;
    if8.b = 8'h83;
    tick();
    check_val("g8_57x83", 32'(if8.y), ref_mul(32'h57, 32'h83, 32'h1D, 8));
    if8.en = 1'b0;
    tick();
    check_val("g8_vld_off", 32'(if8.vld), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
